// File: rtl/mem_arb_defs.sv
// Shared encodings for the unified-memory port arbiter: FSM states and the
// RISC-V load/store funct3 size codes.
package mem_arb_defs;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DATA     = 3'd2,
    RESP     = 3'd3,
    ERRPULSE = 3'd4
  } arb_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store byte enables and lane
// replication, load extraction with sign/zero extension, and misalignment.
module mem_lane_align
  import mem_arb_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rdata[7:0];
    case (addr_lo)
      2'd0: rbyte = rdata[7:0];
      2'd1: rbyte = rdata[15:8];
      2'd2: rbyte = rdata[23:16];
      2'd3: rbyte = rdata[31:24];
      default: rbyte = rdata[7:0];
    endcase
  end

  assign rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Unlisted funct3 codes fall into the default arm and behave as a word access.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    misalign  = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_BU) ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_HU) ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        misalign  = addr_lo[0];
      end
      F3_W: begin
        misalign = |addr_lo;
      end
      default: begin
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between fetch and
// load/store, with a streak limit so fetch is never starved and a ready timeout.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_misalign,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [2:0]  dbg_state
);

  localparam int             SW         = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [7:0]     TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic [7:0]    tmo_cnt;
  logic          acc_data;
  logic          acc_we;
  logic [2:0]    acc_funct3;
  logic [1:0]    acc_lo;

  logic [2:0]  la_funct3;
  logic [1:0]  la_lo;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;
  logic        la_misalign;
  logic        pulse_busy;
  logic        fetch_wins;

  // Requesters hold req until their one-cycle answer pulse (valid, misalign or
  // bus_err); dropping req before the grant withdraws it, after the grant the
  // access still completes. Memory side: mem_req holds until mem_ready.
  assign stall_if  = if_req && !if_valid;
  assign stall_mem = d_req && !d_valid && !d_misalign && !bus_err;
  assign dbg_state = state;

  // Live request fields steer the aligner at grant; the latched access steers it during capture.
  assign la_funct3 = (state == IDLE) ? d_funct3 : acc_funct3;
  assign la_lo     = (state == IDLE) ? d_addr[1:0] : acc_lo;

  mem_lane_align u_align (
    .funct3    (la_funct3),
    .addr_lo   (la_lo),
    .wdata     (d_wdata),
    .rdata     (mem_rdata),
    .be        (la_be),
    .wdata_rep (la_wdata),
    .rdata_ext (la_rdata),
    .misalign  (la_misalign)
  );

  // While an answer pulse is out the requester has not yet reacted, so IDLE waits a cycle.
  assign pulse_busy = if_valid || d_valid || d_misalign || bus_err;
  assign fetch_wins = if_req && (!d_req || streak == STREAK_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      streak     <= '0;
      tmo_cnt    <= '0;
      acc_data   <= 1'b0;
      acc_we     <= 1'b0;
      acc_funct3 <= '0;
      acc_lo     <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      d_misalign <= 1'b0;
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      d_misalign <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!pulse_busy) begin
            if (fetch_wins) begin
              state     <= FETCH;
              streak    <= '0;
              tmo_cnt   <= '0;
              acc_data  <= 1'b0;
              acc_we    <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr & 32'hFFFF_FFFC;
              mem_be    <= 4'b1111;
              mem_wdata <= '0;
            end else if (d_req) begin
              if (!if_req)
                streak <= '0;
              else if (streak != STREAK_MAX)
                streak <= streak + SW'(1);
              acc_data   <= 1'b1;
              acc_we     <= d_we;
              acc_funct3 <= d_funct3;
              acc_lo     <= d_addr[1:0];
              if (la_misalign) begin
                state      <= ERRPULSE;
                d_misalign <= 1'b1;
              end else begin
                state     <= DATA;
                tmo_cnt   <= '0;
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= {d_addr[31:2], 2'b00};
                mem_be    <= d_we ? la_be : 4'b1111;
                mem_wdata <= d_we ? la_wdata : 32'h0;
              end
            end
          end
        end
        FETCH, DATA: begin
          if (mem_ready) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == FETCH)
              if_rdata <= mem_rdata;
            else
              d_rdata <= acc_we ? 32'h0 : la_rdata;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= IDLE;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            tmo_cnt <= tmo_cnt + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (acc_data)
            d_valid <= 1'b1;
          else
            if_valid <= 1'b1;
        end
        ERRPULSE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: zero-wait/stalled memory model,
// hand-computed expectations for lanes, extension, arbitration and timeout.
module tb_mem_port_arbiter;
  import mem_arb_defs::*;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  dbg_state;

  mem_port_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_misalign(d_misalign),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  logic        ready_en;

  assign mem_ready = mem_req && ready_en;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic        seen_req, cap_we, got_valid, got_mis, got_err, stall_ok, stall_done, req_done;
  logic [31:0] cap_addr, cap_wdata, got_rdata;
  logic [3:0]  cap_be;
  int          lat, req_cyc;

  task automatic access(input logic is_fetch, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic done;
    seen_req = 0; cap_we = 0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
    got_valid = 0; got_mis = 0; got_err = 0; got_rdata = '0;
    stall_ok = 1; stall_done = 1; req_done = 1; lat = 0; req_cyc = 0;
    @(negedge clk);
    if (is_fetch) begin
      if_req = 1; if_addr = addr;
    end else begin
      d_req = 1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_req && !seen_req) begin
        seen_req = 1; req_cyc = i;
        cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
      end
      done = is_fetch ? (if_valid || bus_err) : (d_valid || d_misalign || bus_err);
      if (done) begin
        lat = i;
        got_valid  = is_fetch ? if_valid : d_valid;
        got_rdata  = is_fetch ? if_rdata : d_rdata;
        got_mis    = d_misalign;
        got_err    = bus_err;
        stall_done = is_fetch ? stall_if : stall_mem;
        req_done   = mem_req;
        break;
      end
      if (!(is_fetch ? stall_if : stall_mem)) stall_ok = 0;
    end
    if_req = 0; d_req = 0;
    check("access_answered", {31'h0, lat != 0}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  logic prev_req;
  int   n_grants;
  logic late_valid;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h00A0_0093;   // 0x40
    mem[8'h40] = 32'h80FF_1234;   // 0x100
    mem[8'h80] = 32'h1122_3344;   // 0x200
    ready_en = 1;
    rst_n = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_funct3 = '0; d_addr = '0; d_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_req",  mem_req,    0);
    check("rst_if_valid", if_valid,   0);
    check("rst_d_valid",  d_valid,    0);
    check("rst_misalign", d_misalign, 0);
    check("rst_bus_err",  bus_err,    0);
    check("rst_mem_be",   mem_be,     0);
    check("rst_stalls",   {stall_if, stall_mem}, 0);
    check("rst_state",    dbg_state,  0);
    rst_n = 1;

    // fetch only, zero-wait
    access(1, 0, F3_W, 32'h40, 0);
    check("fetch_latency",  lat,        3);
    check("fetch_rdata",    got_rdata,  32'h00A0_0093);
    check("fetch_addr",     cap_addr,   32'h40);
    check("fetch_stall_hi", stall_ok,   1);
    check("fetch_stall_lo", stall_done, 0);

    // loads with extension
    access(0, 0, F3_B, 32'h103, 0);
    check("lb_be",    cap_be,    4'hF);
    check("lb_addr",  cap_addr,  32'h100);
    check("lb_rdata", got_rdata, 32'hFFFF_FF80);
    check("lb_lat",   lat,       3);
    access(0, 0, F3_BU, 32'h103, 0);
    check("lbu_rdata", got_rdata, 32'h0000_0080);
    access(0, 0, F3_H, 32'h102, 0);
    check("lh_rdata", got_rdata, 32'hFFFF_80FF);
    access(0, 0, F3_HU, 32'h102, 0);
    check("lhu_rdata", got_rdata, 32'h0000_80FF);
    access(0, 0, F3_B, 32'h100, 0);
    check("lb0_rdata", got_rdata, 32'h0000_0034);
    access(0, 0, 3'b011, 32'h100, 0);
    check("undef_f3_word", got_rdata, 32'h80FF_1234);

    // stores
    access(0, 1, F3_H, 32'h202, 32'h0000_BEEF);
    check("sh_be",    cap_be,    4'b1100);
    check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    check("sh_addr",  cap_addr,  32'h200);
    check("sh_we",    cap_we,    1);
    check("sh_valid", got_valid, 1);
    access(0, 1, F3_B, 32'h201, 32'h0000_00A5);
    check("sb_be",    cap_be,    4'b0010);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    access(0, 0, F3_W, 32'h200, 0);
    check("store_readback", got_rdata, 32'hBEEF_A544);

    // misaligned accesses
    access(0, 1, F3_W, 32'h201, 32'h1234_5678);
    check("sw_mis_pulse", got_mis,   1);
    check("sw_mis_noreq", seen_req,  0);
    check("sw_mis_novld", got_valid, 0);
    access(0, 0, F3_HU, 32'h101, 0);
    check("lhu_mis_pulse", got_mis,  1);
    check("lhu_mis_noreq", seen_req, 0);

    // contention: both held, four data grants then one fetch
    exp_q = {32'h100, 32'h100, 32'h100, 32'h100, 32'h40, 32'h100};
    @(negedge clk);
    if_addr = 32'h40; d_addr = 32'h100; d_we = 0; d_funct3 = F3_W;
    if_req = 1; d_req = 1; prev_req = 0; n_grants = 0;
    for (int i = 0; i < 200 && n_grants < 6; i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        check("grant_order", mem_addr, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD);
        n_grants++;
      end
      prev_req = mem_req;
    end
    if_req = 0; d_req = 0;
    check("grant_count", n_grants, 6);
    repeat (8) @(negedge clk);

    // timeout
    ready_en = 0;
    access(0, 0, F3_W, 32'h100, 0);
    check("tmo_bus_err",  got_err,       1);
    check("tmo_delay",    lat - req_cyc, 8);
    check("tmo_req_drop", req_done,      0);
    check("tmo_no_valid", got_valid,     0);
    check("tmo_stall",    stall_done,    0);
    late_valid = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_valid || mem_req) late_valid = 1;
    end
    check("tmo_quiet", late_valid, 0);
    ready_en = 1;

    // reset in the middle of a data access
    ready_en = 0;
    @(negedge clk);
    d_req = 1; d_we = 0; d_funct3 = F3_W; d_addr = 32'h100;
    @(negedge clk);
    check("mid_req_up", mem_req, 1);
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_req",   mem_req,   0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_addr",  mem_addr,  0);
    check("mid_rst_pulse", {if_valid, d_valid, d_misalign, bus_err}, 0);
    d_req = 0; rst_n = 1; ready_en = 1;
    access(1, 0, F3_W, 32'h40, 0);
    check("post_rst_lat",   lat,       3);
    check("post_rst_rdata", got_rdata, 32'h00A0_0093);
    access(0, 0, F3_B, 32'h103, 0);
    check("post_rst_load", got_rdata, 32'hFFFF_FF80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
